// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared types and helpers for the push-button debouncer.
//   db_state_t : the four debouncer states (settled low/high and the two
//                "waiting for agreement" states between them)
//   cnt_width  : width of the agreement counter for a given tick threshold
// ---------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_H,
        S_HIGH,
        S_WAIT_L
    } db_state_t;

    // The counter only ever has to hold 0 .. n-1.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level input.
// Ports:
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset, both flops clear to 0
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges behind d
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // The first flop may go metastable; the second gives it a full clock
    // period to resolve before anything downstream looks at the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_fsm.sv
// ---------------------------------------------------------------------------
// debounce_fsm
// Debounces one raw push-button using the divider tick as sample enable.
// A new level is accepted only after STABLE_TICKS consecutive agreeing
// samples; accepted edges produce one-clock press/release pulses.
// Ports:
//   clk      : system clock (rising edge)
//   rst      : asynchronous active-high reset
//   tick     : sample enable, one clk per divider period (may be held high)
//   btn_in   : raw, bouncing, asynchronous button level
//   btn_db   : debounced level (registered)
//   btn_rise : one-clk pulse on an accepted 0->1 change (registered)
//   btn_fall : one-clk pulse on an accepted 1->0 change (registered)
// ---------------------------------------------------------------------------
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_db,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          btn_s;
    db_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          db_nxt, rise_nxt, fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    // Everything that holds state lives here: FSM state, agreement counter
    // and the three registered outputs. Reset clears all of it at once, so
    // a count in progress is simply thrown away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_LOW;
            cnt      <= CNT_ZERO;
            btn_db   <= 1'b0;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            btn_db   <= db_nxt;
            btn_rise <= rise_nxt;
            btn_fall <= fall_nxt;
        end
    end

    // Next state and counter. Nothing moves unless tick is high. The first
    // disagreeing sample already counts as 1, so the threshold is reached
    // on the STABLE_TICKS-th agreeing tick when cnt equals STABLE_TICKS-1.
    // A single contrary sample while waiting falls back to the settled
    // state and restarts the count from scratch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (tick) begin
            case (state)
                S_LOW: begin
                    if (btn_s) begin
                        state_nxt = S_WAIT_H;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                S_WAIT_H: begin
                    if (!btn_s) begin
                        state_nxt = S_LOW;
                        cnt_nxt   = CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!btn_s) begin
                        state_nxt = S_WAIT_L;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                S_WAIT_L: begin
                    if (btn_s) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = S_LOW;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = S_LOW;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Next values of the registered outputs. The pulses default to 0 every
    // cycle, which is what makes them exactly one clk wide regardless of
    // tick; they can only fire on the accepting tick, and rise and fall
    // come from different states so they can never coincide.
    always_comb begin
        db_nxt   = btn_db;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (tick && (cnt == CNT_LAST)) begin
            if ((state == S_WAIT_H) && btn_s) begin
                db_nxt   = 1'b1;
                rise_nxt = 1'b1;
            end else if ((state == S_WAIT_L) && !btn_s) begin
                db_nxt   = 1'b0;
                fall_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// ---------------------------------------------------------------------------
// tb_debounce_fsm
// Directed bench for debounce_fsm with STABLE_TICKS=4 and tick high one clk
// in every four. Inputs are driven 1 time unit after each rising edge and
// outputs are sampled at the same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_debounce_fsm;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic btn_in;
    logic btn_db;
    logic btn_rise;
    logic btn_fall;

    int check_count = 0;
    int error_count = 0;
    int rise_seen   = 0;
    int fall_seen   = 0;
    int both_seen   = 0;
    int rise_base;
    int fall_base;

    always #5 clk = ~clk;

    debounce_fsm #(.STABLE_TICKS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .btn_in   (btn_in),
        .btn_db   (btn_db),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    // One comparison: counted, and reported on mismatch (X counts as wrong).
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one clock's worth of inputs, wait for the edge, then tally pulses.
    task automatic applyStimulus(input logic b, input logic t);
        btn_in = b;
        tick   = t;
        @(posedge clk);
        #1;
        if (btn_rise === 1'b1) rise_seen++;
        if (btn_fall === 1'b1) fall_seen++;
        if (btn_rise === 1'b1 && btn_fall === 1'b1) both_seen++;
    endtask

    // One divider period with a constant button level: three idle clocks and
    // one tick clock. The level is set at the period start, so the 2-flop
    // latency has elapsed before the tick samples it.
    task automatic runPeriod(input logic b);
        applyStimulus(b, 1'b0);
        applyStimulus(b, 1'b0);
        applyStimulus(b, 1'b0);
        applyStimulus(b, 1'b1);
    endtask

    initial begin
        // ---- 1. reset ----
        rst    = 1'b1;
        btn_in = 1'b1;
        tick   = 1'b0;
        #3;
        checkOutput("reset_async_db",   btn_db,   0);
        checkOutput("reset_async_rise", btn_rise, 0);
        checkOutput("reset_async_fall", btn_fall, 0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_held_db", btn_db, 0);
        rst = 1'b0;
        runPeriod(1'b0);
        runPeriod(1'b0);
        checkOutput("post_reset_db", btn_db, 0);
        checkOutput("post_reset_pulses", rise_seen + fall_seen, 0);

        // ---- 2. clean press: accepted on the 4th high tick ----
        runPeriod(1'b1);
        runPeriod(1'b1);
        runPeriod(1'b1);
        checkOutput("press_tick3_db",   btn_db,   0);
        checkOutput("press_tick3_rise", btn_rise, 0);
        runPeriod(1'b1);
        checkOutput("press_tick4_db",   btn_db,   1);
        checkOutput("press_tick4_rise", btn_rise, 1);
        checkOutput("press_tick4_fall", btn_fall, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("press_rise_width", btn_rise, 0);
        checkOutput("press_db_holds",   btn_db,   1);
        checkOutput("press_rise_count", rise_seen, 1);

        // ---- 4. release, with a 1-tick low glitch first ----
        runPeriod(1'b0);
        runPeriod(1'b1);
        checkOutput("release_glitch_db", btn_db, 1);
        checkOutput("release_glitch_nofall", fall_seen, 0);
        runPeriod(1'b0);
        runPeriod(1'b0);
        runPeriod(1'b0);
        checkOutput("release_tick3_db", btn_db, 1);
        runPeriod(1'b0);
        checkOutput("release_tick4_db",   btn_db,   0);
        checkOutput("release_tick4_fall", btn_fall, 1);
        checkOutput("release_tick4_rise", btn_rise, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("release_fall_width", btn_fall, 0);
        checkOutput("release_fall_count", fall_seen, 1);

        // ---- 3. bounce during press: count restarts after the glitch ----
        runPeriod(1'b1);
        runPeriod(1'b1);
        runPeriod(1'b0);
        runPeriod(1'b1);
        runPeriod(1'b1);
        runPeriod(1'b1);
        checkOutput("bounce_tick3_db", btn_db, 0);
        checkOutput("bounce_no_rise",  rise_seen, 1);
        runPeriod(1'b1);
        checkOutput("bounce_tick4_db",   btn_db,   1);
        checkOutput("bounce_tick4_rise", btn_rise, 1);

        // ---- 5. tick gating: no sampling while tick is low ----
        rise_base = rise_seen;
        fall_base = fall_seen;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(i[0], 1'b0);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("gate_db",     btn_db, 1);
        checkOutput("gate_pulses", (rise_seen - rise_base) + (fall_seen - fall_base), 0);

        // ---- continuous tick: release samples every clock ----
        // Edge 1-2 still see the old high level through the synchronizer,
        // edge 3 starts the count, edge 6 is the 4th agreeing sample.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("cont_edge5_db", btn_db, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("cont_edge6_db",   btn_db,   0);
        checkOutput("cont_edge6_fall", btn_fall, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("cont_fall_width", btn_fall, 0);

        // ---- 6. reset mid-count in S_WAIT_H with cnt=3 ----
        runPeriod(1'b1);
        runPeriod(1'b1);
        runPeriod(1'b1);
        checkOutput("midrst_pre_db", btn_db, 0);
        rise_base = rise_seen;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0);
        rst = 1'b0;
        runPeriod(1'b1);
        checkOutput("midrst_tick1_rise", rise_seen - rise_base, 0);
        runPeriod(1'b1);
        runPeriod(1'b1);
        checkOutput("midrst_tick3_db", btn_db, 0);
        runPeriod(1'b1);
        checkOutput("midrst_tick4_db",   btn_db,   1);
        checkOutput("midrst_tick4_rise", btn_rise, 1);
        runPeriod(1'b1);
        checkOutput("midrst_one_pulse", rise_seen - rise_base, 1);

        // ---- asynchronous reset from a settled high level ----
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_db", btn_db, 0);
        checkOutput("never_both",   both_seen, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/debounce_fsm.md
# debounce_fsm

Debounces one raw, asynchronous push-button input using the periodic one-clock `tick` from the clock-divider counter (`cntdiv_n`) as its sample enable. The block synchronizes the input, requires `STABLE_TICKS` consecutive agreeing samples before changing its output level, and emits single-clock press and release pulses. It sits directly downstream of the divider and feeds user-input consumers such as counters, FSMs and display logic.

## Interface
- `STABLE_TICKS`, default 4: number of consecutive ticks with equal samples required to accept a new level; legal range ≥ 2.
- `clk` in 1: system clock; every flop is clocked on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `tick` in 1: sample enable, high for one `clk` per divider period; it may also be held high continuously.
- `btn_in` in 1: raw button level, asynchronous to `clk`, bouncing.
- `btn_db` out 1: debounced level, registered.
- `btn_rise` out 1: one-`clk` pulse on an accepted 0→1 change, registered.
- `btn_fall` out 1: one-`clk` pulse on an accepted 1→0 change, registered.

## Operation
- **Synchronizer.** Two flops reset to 0; `btn_s` is the second flop's output. `btn_in` is never used directly.
- **Sample counter.** `cnt` is `$clog2(STABLE_TICKS)` bits wide, resets to 0, and never exceeds `STABLE_TICKS-1`.
- **States:** `S_LOW`, `S_WAIT_H`, `S_HIGH`, `S_WAIT_L`. Reset state is `S_LOW`.
- **Idle cycles.** On any cycle with `tick=0`: state, `cnt` and `btn_db` hold, and `btn_rise`/`btn_fall` are 0.
- **`S_LOW`, on a tick:**
  - `btn_s=1` → go to `S_WAIT_H`, `cnt<=1`.
  - Otherwise stay.
- **`S_WAIT_H`, on a tick:**
  - `btn_s=0` → go to `S_LOW`, `cnt<=0`. This is a bounce: no pulse.
  - `btn_s=1` and `cnt==STABLE_TICKS-1` → go to `S_HIGH`, `cnt<=0`, `btn_db<=1`, `btn_rise<=1`.
  - `btn_s=1` otherwise → `cnt<=cnt+1`.
- **`S_HIGH`, on a tick:**
  - `btn_s=0` → go to `S_WAIT_L`, `cnt<=1`.
- **`S_WAIT_L`:** mirror of `S_WAIT_H`. A return of `btn_s=1` goes back to `S_HIGH`. Completing the count goes to `S_LOW` with `btn_db<=0` and `btn_fall<=1`.
- **Pulse width.** `btn_rise` and `btn_fall` are high for exactly one `clk` and return to 0 on the next edge, whether or not `tick` is high. They are never both high.
- **Continuous tick.** With `tick` held high, sampling happens every clock; the behaviour is otherwise identical.

## Timing
- **Reset values.** While `rst=1`, all outputs are 0, `state=S_LOW`, `cnt=0` and both synchronizer flops are 0. Reset takes effect immediately (asynchronous), not at the next edge.
- **Reset mid-operation.** Any accumulated count is discarded and no pulse is emitted.
- **Synchronizer latency.** A change on `btn_in` is visible on `btn_s` after 2 `clk` edges.
- **Acceptance latency.**
  - `btn_db` changes at the clock edge of the `STABLE_TICKS`-th consecutive agreeing tick.
  - The matching pulse is asserted in that same cycle, coincident with the first cycle of the new `btn_db` level.
- **Minimum press.** A press shorter than `STABLE_TICKS` sampling ticks produces no output change.

## Structure
- **Package `debounce_pkg`:**
  - `typedef enum logic [1:0] {S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L} db_state_t`.
  - Function `cnt_width(n)` returning `$clog2(n)`.
- **Sub-module `sync_2ff`:** clk, rst, d, q; reset value 0. It is instantiated once and is reusable for other asynchronous inputs.
- **Top level:** the FSM and counter live in `debounce_fsm`, as one sequential block plus one combinational next-state block.

## Test plan
Common setup: `STABLE_TICKS=4`, `tick` high one `clk` in every 4 unless stated otherwise.

1. **Reset.** Assert `rst` with `btn_in=1` → `btn_db`, `btn_rise`, `btn_fall` all 0 immediately. Release `rst` with `btn_in=0` → outputs stay 0.
2. **Clean press.** `btn_in` 0→1 and held → `btn_db=1` at the 4th tick that samples `btn_s=1`. `btn_rise`=1 for exactly one `clk` in that cycle; `btn_fall` stays 0.
3. **Bounce.** `btn_in` high for 2 ticks, low for 1 tick, then high → no `btn_rise` until 4 further consecutive high ticks after the glitch (the counter restarts).
4. **Release.** From `btn_db=1`, drive `btn_in=0` for 4+ ticks → `btn_db` 1→0 and a single `btn_fall` pulse. A 1-tick low glitch alone leaves `btn_db=1`.
5. **Tick gating.** Hold `tick=0` for 100 clks while toggling `btn_in` → no output change and no pulses.
6. **Reset mid-count.** Assert `rst` in `S_WAIT_H` with `cnt=3`, then release `rst` with `btn_in=1` → a full 4 new ticks are needed before `btn_rise`, and exactly one pulse is produced.
